// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch ahead of decode.
// Issues one outstanding request at a time to a variable-latency I-mem,
// buffers {pc, instr} pairs in a small prefetch FIFO and presents the head
// to decode over valid/ready. Branch redirects flush the FIFO and discard
// any response still in flight. Fetch stops after an HLT (opcode 4'hF).
// Optional macro FETCH_PERF_EN adds saturating stall/flush counters;
// without it perf_stall/perf_flush read as zero.
module fetch_stage #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_valid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus2,
  output logic               halted,
  output logic [15:0]        perf_stall,
  output logic [15:0]        perf_flush
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic                outstanding;
  logic                drop;

  logic [INSTR_W-1:0]  q_instr [DEPTH];
  logic [ADDR_W-1:0]   q_pc    [DEPTH];
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count;

  logic resp, push, pop, halt_op, can_issue;

  // A response only counts while a request is outstanding; stale or
  // same-cycle-as-redirect responses never reach the FIFO.
  assign resp      = mem_valid && outstanding;
  assign push      = resp && !drop && !redirect;
  assign pop       = if_valid && if_ready && !redirect;
  assign halt_op   = (mem_rdata[INSTR_W-1 -: 4] == 4'hF);
  // Issuing only with no request in flight and a free slot reserves space
  // for the response, so a push never finds the FIFO full.
  assign can_issue = (state == S_REQ) && !outstanding && (count < CNT_FULL);

  assign if_valid    = (count != '0);
  assign if_instr    = q_instr[rd_ptr];
  assign if_pc       = q_pc[rd_ptr];
  assign if_pc_plus2 = q_pc[rd_ptr] + ADDR_W'(2);

  // Fetch FSM: request issue, response tracking, halt and redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      halted      <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      if (redirect) begin
        state    <= S_REQ;
        fetch_pc <= redirect_pc;
        halted   <= 1'b0;
        // An in-flight request must still be answered; remember to discard it.
        outstanding <= outstanding && !mem_valid;
        drop        <= outstanding && !mem_valid;
      end else begin
        if (resp) begin
          outstanding <= 1'b0;
          drop        <= 1'b0;
        end
        case (state)
          S_REQ: begin
            if (can_issue) begin
              mem_req     <= 1'b1;
              mem_addr    <= fetch_pc;
              fetch_pc    <= fetch_pc + ADDR_W'(2);
              outstanding <= 1'b1;
              state       <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (resp) begin
              if (!drop && halt_op) begin
                state  <= S_HALT;
                halted <= 1'b1;
              end else begin
                state <= S_REQ;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; redirect clears, push and pop may coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; the request address doubles as the instruction's PC.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= mem_rdata;
      q_pc[wr_ptr]    <= mem_addr;
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters: decode back-pressure cycles and redirects taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (if_valid && !if_ready && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
      if (redirect && perf_flush != 16'hFFFF)
        perf_flush <= perf_flush + 16'd1;
    end
  end
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
// Stimulus pushes expected {pc, instr} into a queue; a negedge monitor pops
// and compares on every decode handshake and checks head stability.
module tb_fetch_stage;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_valid = 0;
  logic [15:0] mem_rdata = 0;
  logic        redirect = 0;
  logic [15:0] redirect_pc = 0;
  logic        if_valid;
  logic        if_ready = 0;
  logic [15:0] if_instr, if_pc, if_pc_plus2;
  logic        halted;
  logic [15:0] perf_stall, perf_flush;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2),
    .halted(halted), .perf_stall(perf_stall), .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ins;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          req_cnt = 0;
  int          acc_cnt = 0;
  int          stall_model = 0;
  int          flush_model = 0;
  int          lat = 1;
  bit          mem_auto = 1;
  logic [15:0] last_req_addr = 0;
  logic [15:0] mem [256];
  bit          prev_stall = 0;
  logic [15:0] prev_instr, prev_pc;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Memory model: answers a request lat cycles after the mem_req cycle.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {4'(1 + i % 14), 12'(i)};
    forever begin
      @(negedge clk);
      if (mem_auto && rst_n && mem_req) begin
        logic [15:0] a;
        a = mem_addr;
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1 mem_valid = 1; mem_rdata = mem[a[8:1]];
        @(posedge clk);
        #1 mem_valid = 0;
      end
    end
  end

  // Monitor: request counting, stall model, head stability, scoreboard pops.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req) begin
        req_cnt++;
        last_req_addr = mem_addr;
      end
      if (if_valid && !if_ready) begin
        stall_model++;
        if (prev_stall) begin
          chk("stall_instr_hold", if_instr, prev_instr);
          chk("stall_pc_hold", if_pc, prev_pc);
        end
        prev_stall = 1;
        prev_instr = if_instr;
        prev_pc    = if_pc;
      end else begin
        prev_stall = 0;
      end
      if (if_valid && if_ready) begin
        acc_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %h, required no transfer", if_pc);
        end else begin
          exp_t e;
          logic [15:0] pp;
          e  = sb_q.pop_front();
          pp = e.pc + 16'd2;
          chk("if_pc", if_pc, e.pc);
          chk("if_instr", if_instr, e.ins);
          chk("if_pc_plus2", if_pc_plus2, pp);
        end
      end
    end else begin
      prev_stall = 0;
    end
  end

  task automatic clear_models();
    sb_q.delete();
    req_cnt = 0; acc_cnt = 0; stall_model = 0; flush_model = 0;
  endtask

  task automatic check_perf(input string tag);
    chk({tag, "_perf_stall"}, perf_stall, PERF ? 16'(stall_model) : 16'h0);
    chk({tag, "_perf_flush"}, perf_flush, PERF ? 16'(flush_model) : 16'h0);
  endtask

  task automatic do_reset();
    rst_n = 0; if_ready = 0; redirect = 0; redirect_pc = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_if_valid", 16'(if_valid), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_perf_stall", perf_stall, 16'h0);
    chk("rst_perf_flush", perf_flush, 16'h0);
    clear_models();
    rst_n = 1;
  endtask

  task automatic expect_pop(input logic [15:0] pc, input logic [15:0] ins);
    exp_t e;
    e.pc = pc; e.ins = ins;
    sb_q.push_back(e);
  endtask

  task automatic drain(input int n);
    int target, cyc;
    target = acc_cnt + n;
    cyc = 0;
    if_ready = 1;
    while (acc_cnt < target && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    if_ready = 0;
    checks++;
    if (acc_cnt < target) begin
      errors++;
      $display("FAIL drain_timeout: got %0d transfers, required %0d", acc_cnt, target);
    end
  endtask

  task automatic wait_reqs(input int n);
    int cyc;
    cyc = 0;
    while (req_cnt < n && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    chk("wait_reqs", 16'(req_cnt), 16'(n));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_redirect(input logic [15:0] pc);
    redirect = 1; redirect_pc = pc; flush_model++;
    @(posedge clk); #1;
    redirect = 0;
  endtask

  initial begin
    // Reset and basic sequential fetch, latency 1, decode always ready.
    lat = 1;
    do_reset();
    expect_pop(16'h0000, 16'h1000);
    expect_pop(16'h0002, 16'h2001);
    expect_pop(16'h0004, 16'h3002);
    drain(3);

    // Back-pressure: only DEPTH requests, then fetch stalls; head stays stable.
    do_reset();
    cycles(20);
    chk("bp_req_count", 16'(req_cnt), 16'd4);
    chk("bp_mem_req_idle", 16'(mem_req), 16'h0);
    chk("bp_if_valid", 16'(if_valid), 16'h1);
    check_perf("bp");
    cycles(5);
    chk("bp_req_count_hold", 16'(req_cnt), 16'd4);
    expect_pop(16'h0000, 16'h1000);
    expect_pop(16'h0002, 16'h2001);
    expect_pop(16'h0004, 16'h3002);
    expect_pop(16'h0006, 16'h4003);
    drain(4);

    // Redirect while the request for 0x0006 is in flight (latency 3).
    rst_n = 0;
    lat = 3;
    do_reset();
    wait_reqs(4);
    chk("rd_inflight_addr", last_req_addr, 16'h0006);
    pulse_redirect(16'h0040);
    chk("rd_if_valid_cleared", 16'(if_valid), 16'h0);
    expect_pop(16'h0040, 16'h5020);
    expect_pop(16'h0042, 16'h6021);
    drain(2);
    check_perf("rd");

    // HLT at 0x0004 stops fetch; redirect resumes.
    rst_n = 0;
    lat = 1;
    mem[2] = 16'hF000;
    do_reset();
    expect_pop(16'h0000, 16'h1000);
    expect_pop(16'h0002, 16'h2001);
    expect_pop(16'h0004, 16'hF000);
    drain(3);
    chk("hlt_halted", 16'(halted), 16'h1);
    chk("hlt_req_count", 16'(req_cnt), 16'd3);
    cycles(10);
    chk("hlt_req_count_hold", 16'(req_cnt), 16'd3);
    chk("hlt_halted_hold", 16'(halted), 16'h1);
    pulse_redirect(16'h0010);
    chk("hlt_resume_halted", 16'(halted), 16'h0);
    expect_pop(16'h0010, 16'h9008);
    expect_pop(16'h0012, 16'hA009);
    drain(2);
    mem[2] = 16'h3002;
    check_perf("hlt");

    // PC wrap: redirect to 0xFFFE right out of reset, next PC is 0x0000.
    do_reset();
    pulse_redirect(16'hFFFE);
    expect_pop(16'hFFFE, 16'h40FF);
    expect_pop(16'h0000, 16'h1000);
    drain(2);
    check_perf("wrap");

    // Async reset mid-WAIT with a non-empty FIFO; late response is ignored.
    do_reset();
    wait_reqs(2);
    mem_auto = 0;
    wait_reqs(3);
    cycles(2);
    chk("ar_pre_if_valid", 16'(if_valid), 16'h1);
    rst_n = 0;
    #1;
    chk("ar_if_valid", 16'(if_valid), 16'h0);
    chk("ar_mem_req", 16'(mem_req), 16'h0);
    chk("ar_halted", 16'(halted), 16'h0);
    chk("ar_perf_stall", perf_stall, 16'h0);
    chk("ar_perf_flush", perf_flush, 16'h0);
    clear_models();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    mem_valid = 1; mem_rdata = 16'hF123;
    @(posedge clk); #1;
    mem_valid = 0;
    mem_auto = 1;
    cycles(3);
    chk("ar_late_if_valid", 16'(if_valid), 16'h1);
    chk("ar_late_halted", 16'(halted), 16'h0);
    expect_pop(16'h0000, 16'h1000);
    drain(1);
    chk("ar_scoreboard_empty", 16'(sb_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
